// File: rtl/fma_alnsft_pipe_if.sv
// Request/result bundle between exponent compare, the alignment shifter and the adder.
// The master drives requests and out_ready; the slave (shifter) returns results and in_ready.
interface fma_alnsft_pipe_if #(
    parameter int NCH   = 4,
    parameter int ACC_W = 48,
    parameter int SFT_W = 6,
    parameter int CNT_W = 16
);
    logic                     in_valid;
    logic                     in_ready;
    logic [1:0]               in_mode;
    logic [NCH-1:0]           in_en;
    logic [NCH*ACC_W-1:0]     in_acc;
    logic [NCH*SFT_W-1:0]     in_sft;
    logic                     out_valid;
    logic                     out_ready;
    logic [NCH*(ACC_W+1)-1:0] out_aln;
    logic [NCH-1:0]           out_sticky;
    logic [NCH*ACC_W-1:0]     out_acc;
    logic [CNT_W-1:0]         op_cnt;

    modport master (
        output in_valid, in_mode, in_en, in_acc, in_sft, out_ready,
        input  in_ready, out_valid, out_aln, out_sticky, out_acc, op_cnt
    );

    modport slave (
        input  in_valid, in_mode, in_en, in_acc, in_sft, out_ready,
        output in_ready, out_valid, out_aln, out_sticky, out_acc, op_cnt
    );
endinterface

// File: rtl/fma_alnsft_pipe.sv
// Multi-lane accumulator alignment shifter with guard/sticky generation; latency 1 cycle.
// Single output register: in_ready = !out_valid || out_ready, so a stalled adder freezes all state.
module fma_alnsft_pipe #(
    parameter int NCH   = 4,
    parameter int ACC_W = 48,
    parameter int SFT_W = 6,
    parameter int CNT_W = 16
) (
    input  logic                clk,
    input  logic                reset,
    fma_alnsft_pipe_if.slave    bus
);
    localparam int EW = ACC_W + 1;

    typedef enum logic [1:0] {
        MD_ALIGN     = 2'd0,
        MD_ALIGN_UPD = 2'd1,
        MD_LOAD      = 2'd2,
        MD_CLEAR     = 2'd3
    } mode_e;

    logic             vld_q;
    logic [CNT_W-1:0] cnt_q;
    logic             accept;
    mode_e            mode;

    assign bus.in_ready  = !vld_q || bus.out_ready;
    assign accept        = bus.in_valid && bus.in_ready;
    assign mode          = mode_e'(bus.in_mode);
    assign bus.out_valid = vld_q;
    assign bus.op_cnt    = cnt_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            vld_q <= 1'b0;
            cnt_q <= '0;
        end else if (accept) begin
            vld_q <= 1'b1;
            cnt_q <= cnt_q + CNT_W'(1);
        end else if (bus.out_ready) begin
            vld_q <= 1'b0;
        end
    end

    for (genvar g = 0; g < NCH; g++) begin : g_lane
        logic [ACC_W-1:0] acc_q, acc_d;
        logic [EW-1:0]    aln_q, aln_d;
        logic             st_q, st_d;
        logic [ACC_W-1:0] oacc_q, oacc_d;
        logic [EW-1:0]    ext, sh, lost_mask, aln_sft;
        logic [31:0]      s;
        logic             st;
        logic [ACC_W-1:0] ld_val;

        assign ld_val = bus.in_acc[g*ACC_W +: ACC_W];

        // Shift amounts past the guard position saturate: everything lands in sticky.
        always_comb begin
            s = 32'(bus.in_sft[g*SFT_W +: SFT_W]);
            if (s > 32'(EW)) begin
                s = 32'(EW);
            end
            ext       = {acc_q, 1'b0};
            sh        = ext >> s;
            lost_mask = ~({EW{1'b1}} << s);
            st        = |(ext & lost_mask);
            aln_sft   = {sh[EW-1:1], sh[0] | st};
        end

        always_comb begin
            acc_d  = acc_q;
            aln_d  = '0;
            st_d   = 1'b0;
            oacc_d = acc_q;
            if (bus.in_en[g]) begin
                case (mode)
                    MD_ALIGN: begin
                        aln_d = aln_sft;
                        st_d  = st;
                    end
                    MD_ALIGN_UPD: begin
                        aln_d  = aln_sft;
                        st_d   = st;
                        acc_d  = sh[EW-1:1];
                        oacc_d = sh[EW-1:1];
                    end
                    MD_LOAD: begin
                        acc_d  = ld_val;
                        aln_d  = {ld_val, 1'b0};
                        oacc_d = ld_val;
                    end
                    MD_CLEAR: begin
                        acc_d  = '0;
                        oacc_d = '0;
                    end
                    default: ;
                endcase
            end
        end

        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                acc_q  <= '0;
                aln_q  <= '0;
                st_q   <= 1'b0;
                oacc_q <= '0;
            end else if (accept) begin
                acc_q  <= acc_d;
                aln_q  <= aln_d;
                st_q   <= st_d;
                oacc_q <= oacc_d;
            end
        end

        assign bus.out_aln[g*EW +: EW]       = aln_q;
        assign bus.out_sticky[g]             = st_q;
        assign bus.out_acc[g*ACC_W +: ACC_W] = oacc_q;
    end
endmodule

// File: tb/tb_fma_alnsft_pipe.sv
// Randomized bench for fma_alnsft_pipe against an arithmetic lane model, plus hand-computed anchors.
module tb_fma_alnsft_pipe;
    localparam int NCH = 4;
    localparam int AW  = 48;
    localparam int SW  = 6;
    localparam int CW  = 16;
    localparam int EW  = AW + 1;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    fma_alnsft_pipe_if #(.NCH(NCH), .ACC_W(AW), .SFT_W(SW), .CNT_W(CW)) bus ();

    fma_alnsft_pipe #(.NCH(NCH), .ACC_W(AW), .SFT_W(SW), .CNT_W(CW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_vec = 0;
    int n_err = 0;
    bit chk_on = 1'b0;

    logic [AW-1:0] m_acc  [NCH];
    logic [EW-1:0] m_aln  [NCH];
    logic          m_st   [NCH];
    logic [AW-1:0] m_oacc [NCH];
    logic          m_vld;
    logic [CW-1:0] m_cnt;

    task automatic cmp(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [EW-1:0] d_aln(input int i);
        return bus.out_aln[i*EW +: EW];
    endfunction

    function automatic logic [AW-1:0] d_acc(input int i);
        return bus.out_acc[i*AW +: AW];
    endfunction

    // Right shift of {acc,0}; sticky is whether the dropped low part is nonzero.
    function automatic void align(input logic [AW-1:0] a, input int s,
                                  output logic [EW-1:0] aln, output logic st);
        longint unsigned ext;
        ext = {15'b0, a, 1'b0};
        if (s >= EW) begin
            st  = (a != 0);
            aln = {{(EW-1){1'b0}}, st};
        end else begin
            st  = (ext % (64'd1 << s)) != 0;
            aln = EW'(ext >> s) | EW'(st);
        end
    endfunction

    task automatic model_update();
        logic [AW-1:0] a, ld;
        int s;
        if (!reset) begin
            m_vld = 1'b0;
            m_cnt = '0;
            for (int i = 0; i < NCH; i++) begin
                m_acc[i] = '0; m_aln[i] = '0; m_st[i] = 1'b0; m_oacc[i] = '0;
            end
        end else if (bus.in_valid && (!m_vld || bus.out_ready)) begin
            for (int i = 0; i < NCH; i++) begin
                a  = m_acc[i];
                ld = bus.in_acc[i*AW +: AW];
                s  = int'(bus.in_sft[i*SW +: SW]);
                m_aln[i] = '0; m_st[i] = 1'b0; m_oacc[i] = a;
                if (bus.in_en[i]) begin
                    case (bus.in_mode)
                        2'd0: align(a, s, m_aln[i], m_st[i]);
                        2'd1: begin
                            align(a, s, m_aln[i], m_st[i]);
                            m_acc[i]  = a >> s;
                            m_oacc[i] = a >> s;
                        end
                        2'd2: begin
                            m_acc[i]  = ld;
                            m_aln[i]  = {ld, 1'b0};
                            m_oacc[i] = ld;
                        end
                        default: begin
                            m_acc[i]  = '0;
                            m_oacc[i] = '0;
                        end
                    endcase
                end
            end
            m_vld = 1'b1;
            m_cnt = m_cnt + 1'b1;
        end else if (bus.out_ready) begin
            m_vld = 1'b0;
        end
    endtask

    always @(negedge clk) begin
        if (chk_on) begin
            cmp("out_valid", 64'(bus.out_valid), 64'(m_vld));
            cmp("in_ready", 64'(bus.in_ready), 64'(!m_vld || bus.out_ready));
            cmp("op_cnt", 64'(bus.op_cnt), 64'(m_cnt));
            for (int i = 0; i < NCH; i++) begin
                cmp($sformatf("out_aln%0d", i), 64'(d_aln(i)), 64'(m_aln[i]));
                cmp($sformatf("out_sticky%0d", i), 64'(bus.out_sticky[i]), 64'(m_st[i]));
                cmp($sformatf("out_acc%0d", i), 64'(d_acc(i)), 64'(m_oacc[i]));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic set_lane(input int i, input logic [AW-1:0] acc, input int sft);
        bus.in_acc[i*AW +: AW] = acc;
        bus.in_sft[i*SW +: SW] = SW'(sft);
    endtask

    task automatic op(input logic [1:0] mode, input logic [NCH-1:0] en);
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b1;
        bus.in_mode   = mode;
        bus.in_en     = en;
        tick();
    endtask

    task automatic rand_inputs();
        bus.in_mode = 2'($urandom_range(0, 3));
        bus.in_en   = NCH'($urandom);
        for (int i = 0; i < NCH; i++) begin
            set_lane(i, AW'({$urandom, $urandom}),
                     ($urandom_range(0, 1) != 0) ? int'($urandom_range(0, 8)) : int'($urandom_range(0, 63)));
        end
    endtask

    logic [CW-1:0] s_cnt;
    logic [EW-1:0] s_aln0;
    logic [CW-1:0] need;

    initial begin
        bus.in_valid = 1'b1; bus.out_ready = 1'b1; bus.in_mode = 2'd0;
        bus.in_en = '0; bus.in_acc = '0; bus.in_sft = '0;
        model_update();
        chk_on = 1'b1;

        // Reset held with a request pending
        rand_inputs();
        repeat (3) tick();
        cmp("rst_out_valid", 64'(bus.out_valid), 64'd0);
        cmp("rst_op_cnt", 64'(bus.op_cnt), 64'd0);
        cmp("rst_out_acc0", 64'(d_acc(0)), 64'd0);
        reset = 1'b1;

        set_lane(0, 48'h8000_0000_0001, 0);
        op(2'd2, 4'b0001);
        cmp("first_out_valid", 64'(bus.out_valid), 64'd1);
        set_lane(0, 48'h0, 4);
        op(2'd0, 4'b0001);
        cmp("align4_aln0", 64'(d_aln(0)), 64'h1000_0000_0001);
        cmp("align4_sticky0", 64'(bus.out_sticky[0]), 64'd1);
        cmp("align4_acc0", 64'(d_acc(0)), 64'h8000_0000_0001);

        // Saturated shift
        set_lane(0, 48'h1, 0);  op(2'd2, 4'b0001);
        set_lane(0, 48'h0, 63); op(2'd0, 4'b0001);
        cmp("sat_aln0", 64'(d_aln(0)), 64'h1);
        cmp("sat_sticky0", 64'(bus.out_sticky[0]), 64'd1);
        set_lane(0, 48'h0, 0);  op(2'd2, 4'b0001);
        set_lane(0, 48'h0, 63); op(2'd0, 4'b0001);
        cmp("sat0_aln0", 64'(d_aln(0)), 64'h0);
        cmp("sat0_sticky0", 64'(bus.out_sticky[0]), 64'd0);

        // ALIGN_UPD on every lane, then read back aligned by zero
        for (int i = 0; i < NCH; i++) set_lane(i, 48'hF, 0);
        op(2'd2, 4'b1111);
        set_lane(0, 48'h0, 1); set_lane(1, 48'h0, 2); set_lane(2, 48'h0, 3); set_lane(3, 48'h0, 0);
        op(2'd1, 4'b1111);
        cmp("upd_acc0", 64'(d_acc(0)), 64'h7);
        cmp("upd_acc1", 64'(d_acc(1)), 64'h3);
        cmp("upd_acc2", 64'(d_acc(2)), 64'h1);
        cmp("upd_acc3", 64'(d_acc(3)), 64'hF);
        for (int i = 0; i < NCH; i++) set_lane(i, 48'h0, 0);
        op(2'd0, 4'b1111);
        cmp("upd_aln0", 64'(d_aln(0)), 64'hE);
        cmp("upd_aln3", 64'(d_aln(3)), 64'h1E);

        // Backpressure: five stalled cycles with a new request waiting
        rand_inputs(); op(bus.in_mode, 4'b1111);
        s_cnt  = m_cnt;
        s_aln0 = m_aln[0];
        bus.out_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            rand_inputs();
            tick();
            cmp("stall_in_ready", 64'(bus.in_ready), 64'd0);
            cmp("stall_op_cnt", 64'(bus.op_cnt), 64'(s_cnt));
            cmp("stall_aln0", 64'(d_aln(0)), 64'(s_aln0));
        end
        bus.out_ready = 1'b1;
        for (int k = 0; k < 20; k++) begin
            rand_inputs();
            tick();
        end
        cmp("stream_op_cnt", 64'(bus.op_cnt), 64'(CW'(s_cnt + 20)));

        // Mask and counter wrap
        set_lane(0, 48'h11, 0); set_lane(1, 48'h22, 0); set_lane(2, 48'h33, 0); set_lane(3, 48'h44, 0);
        op(2'd2, 4'b1111);
        op(2'd3, 4'b0101);
        cmp("clr_acc0", 64'(d_acc(0)), 64'h0);
        cmp("clr_acc1", 64'(d_acc(1)), 64'h22);
        cmp("clr_acc2", 64'(d_acc(2)), 64'h0);
        cmp("clr_acc3", 64'(d_acc(3)), 64'h44);
        cmp("clr_aln1", 64'(d_aln(1)), 64'h0);
        need = 16'hFFFF - m_cnt;
        bus.in_mode = 2'd0; bus.in_en = '0;
        for (int k = 0; k < int'(need); k++) tick();
        cmp("cnt_full", 64'(bus.op_cnt), 64'hFFFF);
        op(2'd0, 4'b0000);
        cmp("cnt_wrap", 64'(bus.op_cnt), 64'h0);

        // Random traffic with one asynchronous reset in the middle
        for (int k = 0; k < 3000; k++) begin
            rand_inputs();
            bus.in_valid  = ($urandom_range(0, 3) != 0);
            bus.out_ready = ($urandom_range(0, 3) != 0);
            if (k == 1500) begin
                reset = 1'b0;
                model_update();
                tick();
                reset = 1'b1;
            end else begin
                tick();
            end
        end

        chk_on = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
